// File: rtl/ahbs_mem.sv
// AHB-Lite slave frame-store memory: programmable wait states, two-cycle ERROR response, registered bus grant.
// Optional macro AHBS_BURST_CHECK_EN adds an expected-address tracker that rejects out-of-sequence SEQ beats.
module ahbs_mem #(
  parameter int unsigned ADDR_W      = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        I_AHBS_HCLK,
  input  logic        I_AHBS_HRESET,
  input  logic        I_AHBS_HSEL,
  input  logic [31:0] I_AHBS_HADDR,
  input  logic [1:0]  I_AHBS_HTRANS,
  input  logic [2:0]  I_AHBS_HSIZE,
  input  logic [2:0]  I_AHBS_HBURST,
  input  logic        I_AHBS_HWRITE,
  input  logic [31:0] I_AHBS_HWDATA,
  input  logic        I_AHBS_HBUSREQ,
  output logic [31:0] O_AHBS_HRDATA,
  output logic        O_AHBS_HREADY,
  output logic [1:0]  O_AHBS_HRESP,
  output logic        O_AHBS_HGRANT
);

  localparam int unsigned DEPTH     = 1 << ADDR_W;
  localparam logic [63:0] SPAN      = 64'(DEPTH) * 64'd4;
  localparam logic [2:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_e;

  state_e            state_q, state_d;
  logic [2:0]        wait_q, wait_d;
  logic [ADDR_W-1:0] idx_q;
  logic [1:0]        lo_q;
  logic [2:0]        size_q;
  logic              write_q;
  logic [31:0]       rdata_q;
  logic              grant_q;
  logic [31:0]       mem [DEPTH];

  logic              hready;
  logic              accept;
  logic              acc_err;
  logic              rd_beat;
  logic              wr_beat;
  logic [31:0]       offset;
  logic [3:0]        byte_en;
  logic              unused_bits;

  // Burst type is informational only; beat legality is judged per transfer.
  assign unused_bits = ^{I_AHBS_HBURST, I_AHBS_HTRANS[0]};

  assign hready  = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
  assign accept  = I_AHBS_HSEL && hready && I_AHBS_HTRANS[1];
  assign offset  = I_AHBS_HADDR - BASE_ADDR;
  assign rd_beat = (state_q == S_DATA) && !write_q;
  assign wr_beat = (state_q == S_DATA) && write_q;

`ifdef AHBS_BURST_CHECK_EN
  localparam logic [1:0] HTRANS_IDLE = 2'd0;
  localparam logic [1:0] HTRANS_SEQ  = 2'd3;

  logic [31:0] exp_addr_q;
  logic        exp_vld_q;
  logic        seq_err;

  assign seq_err = (I_AHBS_HTRANS == HTRANS_SEQ) &&
                   (!exp_vld_q || (I_AHBS_HADDR != exp_addr_q));

  // BUSY keeps the tracker armed; IDLE or deselect breaks the sequence.
  always_ff @(posedge I_AHBS_HCLK or posedge I_AHBS_HRESET) begin
    if (I_AHBS_HRESET) begin
      exp_addr_q <= 32'd0;
      exp_vld_q  <= 1'b0;
    end else if (hready) begin
      if (accept) begin
        exp_addr_q <= I_AHBS_HADDR + (32'd1 << I_AHBS_HSIZE);
        exp_vld_q  <= 1'b1;
      end else if (!I_AHBS_HSEL || (I_AHBS_HTRANS == HTRANS_IDLE)) begin
        exp_vld_q  <= 1'b0;
      end
    end
  end
`endif

  // Unsigned offset compare also catches addresses below the window.
  always_comb begin
    acc_err = ({32'd0, offset} >= SPAN) ||
              (I_AHBS_HSIZE > 3'd2) ||
              ((I_AHBS_HSIZE == 3'd1) && I_AHBS_HADDR[0]) ||
              ((I_AHBS_HSIZE == 3'd2) && (I_AHBS_HADDR[1:0] != 2'b00));
`ifdef AHBS_BURST_CHECK_EN
    acc_err = acc_err || seq_err;
`endif
  end

  // NOTE: every combinational output gets a default first so no path through the block leaves a latch.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_WAIT: begin
        if (wait_q == 3'd0) state_d = S_DATA;
        else                wait_d  = wait_q - 3'd1;
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          if (acc_err) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            wait_d  = WAIT_LOAD;
          end else begin
            state_d = S_DATA;
          end
        end
      end
    endcase
  end

  always_comb begin
    byte_en = 4'b0000;
    case (size_q)
      3'd0:    byte_en = 4'b0001 << lo_q;
      3'd1:    byte_en = 4'b0011 << lo_q;
      default: byte_en = 4'b1111;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge I_AHBS_HCLK or posedge I_AHBS_HRESET) begin
    if (I_AHBS_HRESET) begin
      state_q <= S_IDLE;
      wait_q  <= 3'd0;
      idx_q   <= '0;
      lo_q    <= 2'd0;
      size_q  <= 3'd0;
      write_q <= 1'b0;
      rdata_q <= 32'd0;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (accept) begin
        idx_q   <= offset[ADDR_W+1:2];
        lo_q    <= I_AHBS_HADDR[1:0];
        size_q  <= I_AHBS_HSIZE;
        write_q <= I_AHBS_HWRITE;
      end
      if (rd_beat) rdata_q <= mem[idx_q];
      if (hready)  grant_q <= I_AHBS_HBUSREQ;
    end
  end

  // NOTE: the storage array has no reset; contents survive HRESET like a real frame store.
  always_ff @(posedge I_AHBS_HCLK) begin
    if (wr_beat) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[idx_q][8*b +: 8] <= I_AHBS_HWDATA[8*b +: 8];
      end
    end
  end

  // Write commits at the end of the write beat, so a following read beat sees it.
  assign O_AHBS_HRDATA = rd_beat ? mem[idx_q] : rdata_q;
  assign O_AHBS_HREADY = hready;
  assign O_AHBS_HRESP  = {1'b0, (state_q == S_ERR1) || (state_q == S_ERR2)};
  assign O_AHBS_HGRANT = grant_q;

endmodule

// File: tb/tb_ahbs_mem.sv
// Bench for ahbs_mem: two instances (WAIT_STATES=1 and 0) checked every cycle against a
// response-timeline model, plus literal expectations for the directed scenarios.
`timescale 1ns/1ps
module tb_ahbs_mem;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] SPAN = 32'd1024;
`ifdef AHBS_BURST_CHECK_EN
  localparam bit BCHK = 1'b1;
`else
  localparam bit BCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]        hsel, hwrite, hbusreq, hready, hgrant;
  logic [1:0][31:0]  haddr, hwdata, hrdata;
  logic [1:0][1:0]   htrans, hresp;
  logic [1:0][2:0]   hsize, hburst;

  ahbs_mem #(.ADDR_W(8), .BASE_ADDR(BASE), .WAIT_STATES(1)) u_dut_ws1 (
    .I_AHBS_HCLK(clk), .I_AHBS_HRESET(rst), .I_AHBS_HSEL(hsel[0]), .I_AHBS_HADDR(haddr[0]),
    .I_AHBS_HTRANS(htrans[0]), .I_AHBS_HSIZE(hsize[0]), .I_AHBS_HBURST(hburst[0]),
    .I_AHBS_HWRITE(hwrite[0]), .I_AHBS_HWDATA(hwdata[0]), .I_AHBS_HBUSREQ(hbusreq[0]),
    .O_AHBS_HRDATA(hrdata[0]), .O_AHBS_HREADY(hready[0]), .O_AHBS_HRESP(hresp[0]),
    .O_AHBS_HGRANT(hgrant[0]));

  ahbs_mem #(.ADDR_W(8), .BASE_ADDR(BASE), .WAIT_STATES(0)) u_dut_ws0 (
    .I_AHBS_HCLK(clk), .I_AHBS_HRESET(rst), .I_AHBS_HSEL(hsel[1]), .I_AHBS_HADDR(haddr[1]),
    .I_AHBS_HTRANS(htrans[1]), .I_AHBS_HSIZE(hsize[1]), .I_AHBS_HBURST(hburst[1]),
    .I_AHBS_HWRITE(hwrite[1]), .I_AHBS_HWDATA(hwdata[1]), .I_AHBS_HBUSREQ(hbusreq[1]),
    .O_AHBS_HRDATA(hrdata[1]), .O_AHBS_HREADY(hready[1]), .O_AHBS_HRESP(hresp[1]),
    .O_AHBS_HGRANT(hgrant[1]));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- model: a timeline of expected response cycles per instance ----------------
  typedef struct packed {
    logic        rdy;
    logic        err;
    logic        dat;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  sz;
  } beat_t;

  beat_t       mq [2][$];
  logic [31:0] mm [2][256];
  logic [31:0] m_last [2];
  logic        m_grant [2];
`ifdef AHBS_BURST_CHECK_EN
  logic        tv [2];
  logic [31:0] tnext [2];
`endif

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(((a - BASE) >> 2) & 32'hFF);
  endfunction

  function automatic logic spec_err(input logic [31:0] a, input logic [2:0] s);
    return ((a - BASE) >= SPAN) || (s > 3'd2) || ((s == 3'd1) && a[0]) ||
           ((s == 3'd2) && (a[1:0] != 2'b00));
  endfunction

  task automatic model_step(input int d);
    beat_t b;
    beat_t nb;
    logic rdy;
    logic e;
    logic [31:0] w;
    int lane;
    rdy = 1'b1;
    if (mq[d].size() > 0) begin
      b = mq[d].pop_front();
      rdy = b.rdy;
      if (b.dat && b.wr) begin
        w = mm[d][widx(b.addr)];
        for (int k = 0; k < (1 << b.sz); k++) begin
          lane = int'(b.addr[1:0]) + k;
          w[8*lane +: 8] = hwdata[d][8*lane +: 8];
        end
        mm[d][widx(b.addr)] = w;
      end
      if (b.dat && !b.wr) m_last[d] = mm[d][widx(b.addr)];
    end
    if (rdy) begin
      m_grant[d] = hbusreq[d];
      if (hsel[d] && htrans[d][1]) begin
        e = spec_err(haddr[d], hsize[d]);
`ifdef AHBS_BURST_CHECK_EN
        if ((htrans[d] == 2'd3) && (!tv[d] || (haddr[d] != tnext[d]))) e = 1'b1;
        tv[d] = 1'b1;
        tnext[d] = haddr[d] + (32'd1 << hsize[d]);
`endif
        nb = '{rdy: 1'b0, err: e, dat: 1'b0, wr: hwrite[d], addr: haddr[d], sz: hsize[d]};
        if (e) begin
          mq[d].push_back(nb);
          nb.rdy = 1'b1;
          mq[d].push_back(nb);
        end else begin
          for (int k = 0; k < ws_of(d); k++) mq[d].push_back(nb);
          nb.rdy = 1'b1;
          nb.dat = 1'b1;
          mq[d].push_back(nb);
        end
      end
`ifdef AHBS_BURST_CHECK_EN
      else if (!hsel[d] || (htrans[d] == 2'd0)) tv[d] = 1'b0;
`endif
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_last[d] = 32'd0;
      m_grant[d] = 1'b0;
`ifdef AHBS_BURST_CHECK_EN
      tv[d] = 1'b0;
      tnext[d] = 32'd0;
`endif
    end
    forever begin
      @(posedge clk or posedge rst);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          mq[d].delete();
          m_last[d] = 32'd0;
          m_grant[d] = 1'b0;
`ifdef AHBS_BURST_CHECK_EN
          tv[d] = 1'b0;
`endif
        end else begin
          model_step(d);
        end
      end
    end
  end

  // Compare process: every cycle, mid-period, both instances.
  initial begin
    beat_t b;
    logic er, ee;
    logic [31:0] ed;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        er = 1'b1;
        ee = 1'b0;
        ed = m_last[d];
        if (mq[d].size() > 0) begin
          b = mq[d][0];
          er = b.rdy;
          ee = b.err;
          if (b.dat && !b.wr) ed = mm[d][widx(b.addr)];
        end
        check($sformatf("d%0d hready", d), hready[d], er);
        check($sformatf("d%0d hresp", d), hresp[d], {1'b0, ee});
        check($sformatf("d%0d hrdata", d), hrdata[d], ed);
        check($sformatf("d%0d hgrant", d), hgrant[d], m_grant[d]);
      end
    end
  end

  // ---------------- bus driver ----------------
  logic        op_wr   [16];
  logic [31:0] op_addr [16];
  logic [2:0]  op_sz   [16];
  logic [1:0]  op_tr   [16];
  logic [31:0] op_wd   [16];
  logic [31:0] r_data  [16];
  int          r_lat   [16];
  logic [1:0]  r_resp  [16];

  task automatic op(input int i, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                    input logic [1:0] tr, input logic [31:0] wd);
    op_wr[i] = wr; op_addr[i] = a; op_sz[i] = sz; op_tr[i] = tr; op_wd[i] = wd;
  endtask

  // Pipelined master: address of op i overlaps the data phase of op i-1.
  task automatic run(input int d, input int n, input logic [2:0] hb);
    int cyc;
    @(posedge clk); #1;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        hsel[d] = 1'b1; haddr[d] = op_addr[i]; htrans[d] = op_tr[i];
        hsize[d] = op_sz[i]; hwrite[d] = op_wr[i]; hburst[d] = hb;
      end else begin
        hsel[d] = 1'b0; htrans[d] = 2'd0;
      end
      if (i > 0) hwdata[d] = op_wd[i-1];
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!hready[d] && cyc < 40);
      if (!hready[d]) begin
        checks++;
        failures++;
        $display("FAIL d%0d hready timeout: got 0 expected 1", d);
      end
      if (i > 0) begin
        r_data[i-1] = hrdata[d];
        r_lat[i-1]  = cyc;
        r_resp[i-1] = hresp[d];
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    hsel = '0; hwrite = '0; hbusreq = '0; haddr = '0; hwdata = '0;
    htrans = '0; hsize = '0; hburst = '0;
    #2;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d reset hready", d), hready[d], 1);
      check($sformatf("d%0d reset hresp", d), hresp[d], 0);
      check($sformatf("d%0d reset hgrant", d), hgrant[d], 0);
      check($sformatf("d%0d reset hrdata", d), hrdata[d], 0);
    end
    #20 rst = 1'b0;

    // Preload: instance 0 singles, instance 1 an INCR4 write burst.
    op(0, 1, 32'h00, 3'd2, 2'd2, 32'h0000_A5A5);
    op(1, 1, 32'h10, 3'd2, 2'd2, 32'hCAFE_0010);
    run(0, 2, 3'd0);
    check("ws1 write latency", r_lat[0], 2);
    op(0, 1, 32'h00, 3'd2, 2'd2, 32'h1111_0000);
    op(1, 1, 32'h04, 3'd2, 2'd3, 32'h2222_0004);
    op(2, 1, 32'h08, 3'd2, 2'd3, 32'h3333_0008);
    op(3, 1, 32'h0C, 3'd2, 2'd3, 32'h4444_000C);
    run(1, 4, 3'd3);

    // Reset while a write to 0x10 sits in its wait state.
    hbusreq[0] = 1'b1;
    @(posedge clk); #1;
    hsel[0] = 1'b1; htrans[0] = 2'd2; haddr[0] = 32'h10; hsize[0] = 3'd2; hwrite[0] = 1'b1;
    @(posedge clk); #1;
    hsel[0] = 1'b0; htrans[0] = 2'd0; hwdata[0] = 32'h0BAD_0BAD;
    check("pre-reset hready", hready[0], 0);
    check("pre-reset hgrant", hgrant[0], 1);
    #2 rst = 1'b1;
    #1;
    check("mid-reset hready", hready[0], 1);
    check("mid-reset hresp", hresp[0], 0);
    check("mid-reset hgrant", hgrant[0], 0);
    @(negedge clk); #2 rst = 1'b0; hbusreq[0] = 1'b0;
    op(0, 0, 32'h10, 3'd2, 2'd2, 32'h0);
    run(0, 1, 3'd0);
    check("0x10 after reset", r_data[0], 32'hCAFE_0010);

    // Single word write / read with one wait state.
    op(0, 1, 32'h20, 3'd2, 2'd2, 32'hDEAD_BEEF);
    run(0, 1, 3'd0);
    op(0, 0, 32'h20, 3'd2, 2'd2, 32'h0);
    run(0, 1, 3'd0);
    check("read 0x20", r_data[0], 32'hDEAD_BEEF);
    check("read 0x20 latency", r_lat[0], 2);
    check("read 0x20 resp", r_resp[0], 0);

    // Byte and halfword lane merges.
    op(0, 1, 32'h20, 3'd2, 2'd2, 32'h1122_3344);
    op(1, 1, 32'h21, 3'd0, 2'd2, 32'h0000_AA00);
    op(2, 0, 32'h20, 3'd2, 2'd2, 32'h0);
    op(3, 1, 32'h22, 3'd1, 2'd2, 32'h5566_0000);
    op(4, 0, 32'h20, 3'd2, 2'd2, 32'h0);
    run(0, 5, 3'd0);
    check("byte merge", r_data[2], 32'h1122_AA44);
    check("half merge", r_data[4], 32'h5566_AA44);

    // Error responses, then memory untouched.
    op(0, 0, 32'h02,  3'd2, 2'd2, 32'h0);
    op(1, 1, 32'h02,  3'd2, 2'd2, 32'hFFFF_FFFF);
    op(2, 0, 32'h400, 3'd2, 2'd2, 32'h0);
    op(3, 0, 32'h00,  3'd3, 2'd2, 32'h0);
    op(4, 0, 32'h21,  3'd1, 2'd2, 32'h0);
    op(5, 0, 32'h00,  3'd2, 2'd2, 32'h0);
    run(0, 6, 3'd0);
    check("misaligned word resp", r_resp[0], 1);
    check("misaligned word latency", r_lat[0], 2);
    check("misaligned write resp", r_resp[1], 1);
    check("out of range resp", r_resp[2], 1);
    check("hsize 3 resp", r_resp[3], 1);
    check("odd half resp", r_resp[4], 1);
    check("0x00 unchanged", r_data[5], 32'h0000_A5A5);

    // INCR4 read, no wait states: four back-to-back beats.
    op(0, 0, 32'h00, 3'd2, 2'd2, 32'h0);
    op(1, 0, 32'h04, 3'd2, 2'd3, 32'h0);
    op(2, 0, 32'h08, 3'd2, 2'd3, 32'h0);
    op(3, 0, 32'h0C, 3'd2, 2'd3, 32'h0);
    run(1, 4, 3'd3);
    check("incr4 beat0", r_data[0], 32'h1111_0000);
    check("incr4 beat1", r_data[1], 32'h2222_0004);
    check("incr4 beat2", r_data[2], 32'h3333_0008);
    check("incr4 beat3", r_data[3], 32'h4444_000C);
    for (int i = 0; i < 4; i++) check($sformatf("incr4 gap beat%0d", i), r_lat[i], 1);

    // Read-after-write back-to-back, then an INCR running off the top word.
    op(0, 1, 32'h30, 3'd2, 2'd2, 32'h1357_9BDF);
    op(1, 0, 32'h30, 3'd2, 2'd2, 32'h0);
    run(1, 2, 3'd0);
    check("raw forward", r_data[1], 32'h1357_9BDF);
    op(0, 1, 32'h3F8, 3'd2, 2'd2, 32'hAAAA_03F8);
    op(1, 1, 32'h3FC, 3'd2, 2'd3, 32'hBBBB_03FC);
    op(2, 1, 32'h400, 3'd2, 2'd3, 32'hCCCC_0400);
    op(3, 0, 32'h3FC, 3'd2, 2'd2, 32'h0);
    run(1, 4, 3'd1);
    check("top beat0 resp", r_resp[0], 0);
    check("top beat1 resp", r_resp[1], 0);
    check("past-top resp", r_resp[2], 1);
    check("top word", r_data[3], 32'hBBBB_03FC);

    // Grant: rises one edge after request; drop during wait holds until HREADY high.
    @(posedge clk); #1 hbusreq[0] = 1'b1;
    @(negedge clk);
    check("grant before edge", hgrant[0], 0);
    @(posedge clk); #1;
    check("grant after edge", hgrant[0], 1);
    hsel[0] = 1'b1; htrans[0] = 2'd2; haddr[0] = 32'h20; hsize[0] = 3'd2; hwrite[0] = 1'b0;
    @(posedge clk); #1;
    hsel[0] = 1'b0; htrans[0] = 2'd0; hbusreq[0] = 1'b0;
    check("wait hready", hready[0], 0);
    @(posedge clk); #1;
    check("grant held through wait", hgrant[0], 1);
    check("data hready", hready[0], 1);
    @(posedge clk); #1;
    check("grant released", hgrant[0], 0);

    // SEQ that skips a word after an NSEQ word at 0x00.
    op(0, 0, 32'h00, 3'd2, 2'd2, 32'h0);
    op(1, 0, 32'h08, 3'd2, 2'd3, 32'h0);
    run(1, 2, 3'd1);
    check("seq skip resp", r_resp[1], BCHK ? 32'd1 : 32'd0);

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahbs_mem.md
Name: ahbs_mem

Overview:
- AHB-Lite-style slave memory with single-master bus grant. It is the responder end of the DMA's AHB master port (HADDR/HTRANS/HSIZE/HBURST/HWRITE/HWDATA in, HRDATA/HREADY/HRESP out, HBUSREQ/HGRANT handshake).
- Serves as the image frame store the DMA reads pixels from and writes rotated pixels back to.
- Supports programmable wait states and ERROR responses.

Parameters:
- ADDR_W, 8: word-address bits; depth = 2^ADDR_W 32-bit words.
- BASE_ADDR, 32'h0000_0000: byte base address of the memory window.
- WAIT_STATES, 1: HREADY-low cycles inserted per data phase; legal range 0..7.

Ports:
- I_AHBS_HCLK  input  1  clock, rising edge.
- I_AHBS_HRESET  input  1  reset; asynchronous, active-high.
- I_AHBS_HSEL  input  1  slave select.
- I_AHBS_HADDR  input  32  byte address.
- I_AHBS_HTRANS  input  2  0 IDLE, 1 BUSY, 2 NSEQ, 3 SEQ.
- I_AHBS_HSIZE  input  3  0 byte, 1 half, 2 word.
- I_AHBS_HBURST  input  3  burst type (SINGLE/INCR/INCR4/8/16).
- I_AHBS_HWRITE  input  1  1 = write.
- I_AHBS_HWDATA  input  32  write data (data phase).
- I_AHBS_HBUSREQ  input  1  master bus request.
- O_AHBS_HRDATA  output  32  read data.
- O_AHBS_HREADY  output  1  transfer-done / accept.
- O_AHBS_HRESP  output  2  0 OKAY, 1 ERROR.
- O_AHBS_HGRANT  output  1  bus grant.

Behaviour:
- Reset (async, any time, including mid-burst):
  - Outputs go to HRDATA=0, HREADY=1, HRESP=0, HGRANT=0.
  - FSM goes to S_IDLE. Any pending write is discarded.
  - Memory array is not cleared.
- Address-phase acceptance: on a rising edge where HSEL=1, HREADY(out)=1 and HTRANS is NSEQ or SEQ. The block registers HADDR, HSIZE and HWRITE. IDLE/BUSY and HSEL=0 produce a zero-wait OKAY and no access.
- Error check at acceptance. Any of the following causes an ERROR:
  - (HADDR - BASE_ADDR) >= 4*2^ADDR_W (includes HADDR < BASE_ADDR via unsigned wrap);
  - HSIZE > 2;
  - halfword with HADDR[0]=1;
  - word with HADDR[1:0]!=0.
- FSM states S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2:
  - S_IDLE: HREADY=1, HRESP=0. Valid accept goes to S_WAIT if WAIT_STATES>0, else S_DATA. Error accept goes to S_ERR1.
  - S_WAIT: HREADY=0. Down-counter loaded with WAIT_STATES-1 at acceptance; moves to S_DATA when counter = 0.
  - S_DATA: HREADY=1, HRESP=0.
    - Read: HRDATA = mem[word addr], full 32 bits regardless of HSIZE.
    - Write: the byte lanes selected by HSIZE and HADDR[1:0] (little-endian) are written from HWDATA at this edge.
    - A new acceptance in the same cycle follows the S_IDLE rules (pipelined back-to-back). Otherwise the FSM returns to S_IDLE.
  - S_ERR1: HREADY=0, HRESP=1. Always moves to S_ERR2.
  - S_ERR2: HREADY=1, HRESP=1. No memory access. Acceptance in this cycle is allowed.
- Latency: read data and write commit occur WAIT_STATES+1 cycles after acceptance. Each beat of a burst costs WAIT_STATES+1 cycles.
- HRDATA holds its last value outside S_DATA reads.
- Address wrap: none. An INCR burst running past the top word errors on that beat; earlier beats complete normally.
- Grant: HGRANT is registered. HGRANT <= HBUSREQ, updated only on edges where HREADY(out)=1, so grant never changes mid wait state.
- Simultaneous read-after-write to the same address in back-to-back beats returns the newly written data.

Optional Feature:
- Macro AHBS_BURST_CHECK_EN.
- Defined: an extra registered expected-address tracker is added. Each SEQ beat must satisfy both:
  - HADDR = previous beat's HADDR + (1<<HSIZE);
  - it follows an accepted NSEQ/SEQ without an intervening IDLE. BUSY is allowed.
  
  A violation gives the two-cycle ERROR response and no access.
- Undefined: SEQ is treated exactly like NSEQ; no tracker logic is synthesised.

Test Plan:
- Reset mid-burst: assert HRESET during S_WAIT of a write to 0x10 -> HREADY=1, HRESP=0, HGRANT=0 immediately; a subsequent read of 0x10 returns its pre-burst value.
- WAIT_STATES=1, single word write 0xDEADBEEF to 0x20, then read 0x20 -> HREADY low 1 cycle per beat; read returns 0xDEADBEEF 2 cycles after acceptance.
- Byte write 0xAA to 0x21 over word 0x11223344 -> read 0x20 returns 0x1122AA44. Halfword write 0x5566 to 0x22 -> read returns 0x5566AA44.
- INCR4 read 0x00..0x0C with WAIT_STATES=0 -> four consecutive HREADY=1 beats returning the preloaded words, no gaps.
- Errors:
  - word read at 0x02 -> HREADY=0/HRESP=1, then HREADY=1/HRESP=1, memory unchanged.
  - with ADDR_W=8, access at 0x400 -> same ERROR response.
- Grant: HBUSREQ=1 while idle -> HGRANT=1 next edge. Drop HBUSREQ during a wait state -> HGRANT falls only after HREADY returns high. With AHBS_BURST_CHECK_EN, a SEQ to 0x08 after NSEQ word at 0x00 -> ERROR.
